segment_driver: RTL and testbench
=================================

SEGMENT_DRIVER -- requirements
Module: segment_driver

Interface
REQ-001 SHALL have parameter BLINK_DIV, default 500000: clk cycles per blink half-period (min 2).
REQ-002 SHALL have port clk  input  1  the single system clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port column_scan_signal  input  6  one-cold column select from the scan stage; bit5 = leftmost digit (hour tens), bit0 = seconds units.
REQ-005 SHALL have port digit_bcd  input  24  six BCD digits; digit i at bits [4i+3:4i], digit5 = hour tens.
REQ-006 SHALL have port blink_mask  input  6  per-digit blink enable, bit i = digit i.
REQ-007 SHALL have port dp_mask  input  6  per-digit decimal point on.
REQ-008 SHALL have port lzb_en  input  1  leading-zero blanking of digit5.
REQ-009 SHALL have port column_out  output  6  registered active-low column drive.
REQ-010 SHALL have port seg_out  output  8  registered active-high segments {dp,g,f,e,d,c,b,a}.
REQ-011 SHALL have port scan_err  output  1  sticky flag: invalid column code seen.

Function
REQ-012 SHALL hold a 24-bit frame snapshot, loaded from digit_bcd in the cycle column_scan_signal == 6'b111110 (last column), so one full frame never mixes old and new digits.
REQ-013 SHALL present column_out and seg_out exactly 1 cycle after the column_scan_signal they correspond to (column and segments aligned).
REQ-014 SHALL decode the snapshot digit of the active column: 0-9 to standard 7-seg patterns; codes 10-15 to pattern g-only (8'h40).
REQ-015 SHALL force the segment field (g..a) to zero for digit5 when lzb_en=1 and snapshot digit5 == 0.
REQ-016 SHALL run a blink counter 0..BLINK_DIV-1 and toggle blink_phase on wrap; when blink_phase=0 and blink_mask bit of active digit = 1, seg_out SHALL be 8'h00 (dp included).
REQ-017 SHALL set seg_out[7] from dp_mask of the active digit unless blanked by REQ-016.
REQ-018 SHALL treat any column_scan_signal not exactly one-cold as invalid: next cycle column_out = 6'b111111, seg_out = 8'h00, scan_err set; no snapshot load.
REQ-019 SHALL keep scan_err set until reset.
REQ-020 SHALL apply blink_mask, dp_mask, lzb_en live (not snapshotted).

Reset
REQ-021 SHALL on rst=1 clear: snapshot = 0, blink counter = 0, blink_phase = 1, column_out = 6'b111111, seg_out = 8'h00, scan_err = 0.
REQ-022 SHALL give reset priority over snapshot load and invalid-code detection in the same cycle; first valid output appears 1 cycle after the first non-reset cycle.

Structure
REQ-023 SHALL take NUM_DIGITS=6, bcd_t (4-bit) and the segment pattern constants from shared package clock_pkg.
REQ-024 SHALL instantiate one combinational sub-module bcd_to_7seg (4-bit in, 7-bit out) for decoding.

Verification
REQ-025 Reset then scan 011111,101111,...,111110 with digit_bcd=24'h123456 (loaded at prior 111110) -> column_out echoes 1 cycle later; seg_out = 0x06,0x5B,0x4F,0x66,0x6D,0x7D.
REQ-026 Change digit_bcd mid-frame (at column 110111) -> current frame unchanged; new digits shown from next frame's first column.
REQ-027 lzb_en=1, digit5=0, dp_mask=6'b100000 -> column 011111 gives seg_out = 8'h80; lzb_en=0 gives 8'hBF.
REQ-028 BLINK_DIV=4, blink_mask=6'b000011 -> digits 1,0 blank for 4 cycles, visible 4 cycles, repeating; other digits unaffected.
REQ-029 Inject column 6'b001111 -> next cycle column_out=111111, seg_out=0, scan_err=1 and stays 1 after valid scanning resumes, cleared only by rst.
REQ-030 digit code 4'hB at active column -> seg_out = 8'h40; assert rst mid-frame -> outputs go to reset values next cycle.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared definitions for the clock display datapath: digit count, BCD type,
// seven-segment patterns and column-select helpers.
package clock_pkg;

  localparam int NUM_DIGITS = 6;

  typedef logic [3:0] bcd_t;

  // Segment patterns in {g,f,e,d,c,b,a} order, active-high
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Column codes: all columns off, and the last column of a frame
  localparam logic [5:0] COL_NONE = 6'b111111;
  localparam logic [5:0] COL_LAST = 6'b111110;

  // True when exactly one bit of the column select is low
  function automatic logic is_one_cold(input logic [5:0] col);
    logic [5:0] hot;
    hot = ~col;
    return (hot != 6'd0) && ((hot & (hot - 6'd1)) == 6'd0);
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to seven-segment decoder; non-decimal codes show a dash.
import clock_pkg::*;

module bcd_to_7seg (
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Map each BCD code to its segment pattern, codes 10-15 to g-only
  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/segment_driver.sv
// Six-digit multiplexed display driver: snapshots the digits once per frame,
// decodes the active column, applies blanking/blink/decimal point and
// registers column and segment drive together.
import clock_pkg::*;

module segment_driver #(
  parameter int BLINK_DIV = 500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  column_scan_signal,
  input  logic [23:0] digit_bcd,
  input  logic [5:0]  blink_mask,
  input  logic [5:0]  dp_mask,
  input  logic        lzb_en,
  output logic [5:0]  column_out,
  output logic [7:0]  seg_out,
  output logic        scan_err
);

  localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [23:0]      snapshot;
  logic [CNT_W-1:0] blink_cnt;
  logic             blink_phase;

  logic             col_valid;
  logic [2:0]       active_idx;
  bcd_t             active_digit;
  logic [6:0]       decoded;
  logic [6:0]       seg_field;
  logic             blanked;
  logic [7:0]       next_seg;

  // Validate the column code and find which digit it selects
  always_comb begin
    col_valid  = is_one_cold(column_scan_signal);
    active_idx = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!column_scan_signal[i]) active_idx = 3'(i);
    end
    active_digit = snapshot[{active_idx, 2'b00} +: 4];
  end

  bcd_to_7seg u_decoder (
    .bcd (active_digit),
    .seg (decoded)
  );

  // Apply leading-zero blanking, blink blanking and decimal point
  always_comb begin
    seg_field = decoded;
    if (active_idx == 3'd5 && lzb_en && active_digit == 4'd0) seg_field = SEG_BLANK;
    blanked  = !blink_phase && blink_mask[active_idx];
    next_seg = blanked ? 8'h00 : {dp_mask[active_idx], seg_field};
  end

  // Free-running blink timebase; phase flips every BLINK_DIV cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (blink_cnt == CNT_W'(BLINK_DIV - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + 1'b1;
    end
  end

  // Register outputs one cycle behind the scan and reload the frame snapshot
  // on the last column so the next frame starts with fresh digits
  always_ff @(posedge clk) begin
    if (rst) begin
      snapshot   <= '0;
      column_out <= COL_NONE;
      seg_out    <= 8'h00;
      scan_err   <= 1'b0;
    end else if (!col_valid) begin
      column_out <= COL_NONE;
      seg_out    <= 8'h00;
      scan_err   <= 1'b1;
    end else begin
      column_out <= column_scan_signal;
      seg_out    <= next_seg;
      if (column_scan_signal == COL_LAST) snapshot <= digit_bcd;
    end
  end

endmodule

// File: tb/tb_segment_driver.sv
// Self-checking bench for segment_driver: directed vector table, blink
// sequence and randomized scanning against a behavioural display model.
module tb_segment_driver;

  localparam int BLINK_DIV = 4;

  logic        clk;
  logic        rst;
  logic [5:0]  column_scan_signal;
  logic [23:0] digit_bcd;
  logic [5:0]  blink_mask;
  logic [5:0]  dp_mask;
  logic        lzb_en;
  logic [5:0]  column_out;
  logic [7:0]  seg_out;
  logic        scan_err;

  int checkCount = 0;
  int errorCount = 0;

  segment_driver #(.BLINK_DIV(BLINK_DIV)) dut (
    .clk                (clk),
    .rst                (rst),
    .column_scan_signal (column_scan_signal),
    .digit_bcd          (digit_bcd),
    .blink_mask         (blink_mask),
    .dp_mask            (dp_mask),
    .lzb_en             (lzb_en),
    .column_out         (column_out),
    .seg_out            (seg_out),
    .scan_err           (scan_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [5:0]  col;
    logic [23:0] bcd;
    logic [5:0]  blink;
    logic [5:0]  dp;
    logic        lzb;
    logic [5:0]  expCol;
    logic [7:0]  expSeg;
    logic        expErr;
  } vec_t;

  vec_t vecs[$];

  logic [7:0] patTab [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                              8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  // Behavioural model state: displayed frame, cycles since reset, error flag
  logic [23:0] mSnap = '0;
  int          mK = 0;
  logic        mErr = 1'b0;
  logic [5:0]  mCol;
  logic [7:0]  mSeg;
  logic        mErrOut;

  // Predict the outputs one cycle after the given inputs
  task automatic modelStep(input logic r, input logic [5:0] c, input logic [23:0] bcd,
                           input logic [5:0] blink, input logic [5:0] dp, input logic lzb);
    int zeros;
    int idx;
    logic [3:0] d;
    logic [7:0] pat;
    if (r) begin
      mSnap = '0;
      mK    = 0;
      mErr  = 1'b0;
      mCol  = 6'b111111;
      mSeg  = 8'h00;
    end else begin
      zeros = 0;
      idx   = 0;
      for (int i = 0; i < 6; i++) begin
        if (!c[i]) begin
          zeros++;
          idx = i;
        end
      end
      if (zeros != 1) begin
        mErr = 1'b1;
        mCol = 6'b111111;
        mSeg = 8'h00;
      end else begin
        d   = 4'(mSnap >> (4 * idx));
        pat = (d <= 4'd9) ? patTab[d] : 8'h40;
        if (idx == 5 && lzb && d == 4'd0) pat = 8'h00;
        if (dp[idx]) pat = pat | 8'h80;
        if (blink[idx] && ((mK / BLINK_DIV) % 2 == 1)) pat = 8'h00;
        mCol = c;
        mSeg = pat;
        if (c == 6'b111110) mSnap = bcd;
      end
      mK++;
    end
    mErrOut = mErr;
  endtask

  // Drive one cycle of inputs, advance the model, sample after the edge
  task automatic applyStimulus(input logic r, input logic [5:0] c, input logic [23:0] bcd,
                               input logic [5:0] blink, input logic [5:0] dp, input logic lzb);
    rst                = r;
    column_scan_signal = c;
    digit_bcd          = bcd;
    blink_mask         = blink;
    dp_mask            = dp;
    lzb_en             = lzb;
    modelStep(r, c, bcd, blink, dp, lzb);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [5:0] expCol,
                             input logic [7:0] expSeg, input logic expErr);
    checkCount += 3;
    if (column_out !== expCol) begin
      errorCount++;
      $display("[TB] FAIL %s column_out got %b expected %b", name, column_out, expCol);
    end
    if (seg_out !== expSeg) begin
      errorCount++;
      $display("[TB] FAIL %s seg_out got %h expected %h", name, seg_out, expSeg);
    end
    if (scan_err !== expErr) begin
      errorCount++;
      $display("[TB] FAIL %s scan_err got %b expected %b", name, scan_err, expErr);
    end
  endtask

  function automatic void addVec(input logic r, input logic [5:0] c, input logic [23:0] bcd,
                                 input logic [5:0] dp, input logic lzb,
                                 input logic [5:0] ec, input logic [7:0] es, input logic ee);
    vec_t v;
    v.rst = r; v.col = c; v.bcd = bcd; v.blink = 6'b0; v.dp = dp; v.lzb = lzb;
    v.expCol = ec; v.expSeg = es; v.expErr = ee;
    vecs.push_back(v);
  endfunction

  logic [7:0] blinkExp [16];

  initial begin
    // Directed frame, mid-frame change, blanking, dash codes, invalid codes, reset
    addVec(1, 6'b111111, 24'h000000, 6'b000000, 0, 6'b111111, 8'h00, 0);
    addVec(0, 6'b111110, 24'h123456, 6'b000000, 0, 6'b111110, 8'h3F, 0);
    addVec(0, 6'b011111, 24'h123456, 6'b000000, 0, 6'b011111, 8'h06, 0);
    addVec(0, 6'b101111, 24'h123456, 6'b000000, 0, 6'b101111, 8'h5B, 0);
    addVec(0, 6'b110111, 24'h987654, 6'b000000, 0, 6'b110111, 8'h4F, 0);
    addVec(0, 6'b111011, 24'h987654, 6'b000000, 0, 6'b111011, 8'h66, 0);
    addVec(0, 6'b111101, 24'h987654, 6'b000000, 0, 6'b111101, 8'h6D, 0);
    addVec(0, 6'b111110, 24'h987654, 6'b000000, 0, 6'b111110, 8'h7D, 0);
    addVec(0, 6'b011111, 24'h987654, 6'b000000, 0, 6'b011111, 8'h6F, 0);
    addVec(0, 6'b101111, 24'h987654, 6'b000000, 0, 6'b101111, 8'h7F, 0);
    addVec(0, 6'b110111, 24'h987654, 6'b000000, 0, 6'b110111, 8'h07, 0);
    addVec(0, 6'b111011, 24'h987654, 6'b000000, 0, 6'b111011, 8'h7D, 0);
    addVec(0, 6'b111101, 24'h987654, 6'b000000, 0, 6'b111101, 8'h6D, 0);
    addVec(0, 6'b111110, 24'h012345, 6'b000000, 0, 6'b111110, 8'h66, 0);
    addVec(0, 6'b011111, 24'h012345, 6'b100000, 1, 6'b011111, 8'h80, 0);
    addVec(0, 6'b011111, 24'h012345, 6'b100000, 0, 6'b011111, 8'hBF, 0);
    addVec(0, 6'b101111, 24'h012345, 6'b100000, 1, 6'b101111, 8'h06, 0);
    addVec(0, 6'b111110, 24'hAB0000, 6'b000000, 0, 6'b111110, 8'h6D, 0);
    addVec(0, 6'b011111, 24'hAB0000, 6'b000000, 0, 6'b011111, 8'h40, 0);
    addVec(0, 6'b101111, 24'hAB0000, 6'b000000, 0, 6'b101111, 8'h40, 0);
    addVec(0, 6'b001111, 24'hAB0000, 6'b000000, 0, 6'b111111, 8'h00, 1);
    addVec(0, 6'b111110, 24'h000000, 6'b000000, 0, 6'b111110, 8'h3F, 1);
    addVec(0, 6'b111111, 24'h000000, 6'b000000, 0, 6'b111111, 8'h00, 1);
    addVec(1, 6'b101111, 24'h000000, 6'b000000, 0, 6'b111111, 8'h00, 0);
    addVec(0, 6'b011111, 24'h000000, 6'b000000, 0, 6'b011111, 8'h3F, 0);
    addVec(0, 6'b000000, 24'h000000, 6'b000000, 0, 6'b111111, 8'h00, 1);

    rst = 1'b1; column_scan_signal = 6'b111111; digit_bcd = '0;
    blink_mask = '0; dp_mask = '0; lzb_en = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].col, vecs[i].bcd, vecs[i].blink, vecs[i].dp, vecs[i].lzb);
      checkOutput($sformatf("vec%0d", i), vecs[i].expCol, vecs[i].expSeg, vecs[i].expErr);
    end

    // Blink on digits 1,0 with dp everywhere: digit1 alternates 4 visible / 4 blank
    for (int k = 0; k < 16; k++) blinkExp[k] = ((k / 4) % 2 == 0) ? 8'hBF : 8'h00;
    applyStimulus(1, 6'b111111, 24'h0, 6'b000011, 6'b111111, 0);
    checkOutput("blink_reset", 6'b111111, 8'h00, 0);
    for (int k = 0; k < 16; k++) begin
      applyStimulus(0, 6'b111101, 24'h0, 6'b000011, 6'b111111, 0);
      checkOutput($sformatf("blink_d1_%0d", k), 6'b111101, blinkExp[k], 0);
    end
    for (int k = 0; k < 8; k++) begin
      applyStimulus(0, 6'b111011, 24'h0, 6'b000011, 6'b111111, 0);
      checkOutput($sformatf("blink_d2_%0d", k), 6'b111011, 8'hBF, 0);
    end

    // Randomized scanning against the model
    applyStimulus(1, 6'b111111, 24'h0, 6'b0, 6'b0, 0);
    checkOutput("rand_reset", mCol, mSeg, mErrOut);
    for (int n = 0; n < 600; n++) begin
      logic        r;
      logic [5:0]  c;
      logic [23:0] b;
      r = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 24) == 0) c = 6'($urandom);
      else c = ~(6'b000001 << $urandom_range(0, 5));
      b = 24'($urandom);
      if ($urandom_range(0, 2) == 0) b[23:20] = 4'd0;
      applyStimulus(r, c, b, 6'($urandom), 6'($urandom), 1'($urandom));
      checkOutput($sformatf("rand%0d", n), mCol, mSeg, mErrOut);
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
